// File: rtl/fifo_flex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flex_pkg
// Description : Shared constants and helper function for the fifo_flex
//               buffer: default geometry, default thresholds and a ceiling
//               log2 used to size pointers and the occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_flex_pkg;

  localparam int FIFO_DEFAULT_DATA_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH      = 6;
  localparam int FIFO_DEFAULT_AE_LEVEL   = 1;

  // Ceiling log2; returns 0 for v <= 1. Usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage : fifo_flex_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Circular slot pointer for fifo_flex. Wraps explicitly from
//               DEPTH-1 to 0 so that non-power-of-two depths work.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset (pointer -> 0)
//               clr_i  - synchronous clear, wins over inc_i
//               inc_i  - advance pointer by one slot
//               ptr_o  - current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
  parameter int DEPTH = 6,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flex
// Description : First-word-fall-through FIFO of arbitrary depth with
//               occupancy count, programmable almost-full/almost-empty
//               thresholds, synchronous flush and sticky overflow/underflow.
// Ports       : clk, rst       - clock, async active-high reset
//               data_write     - write data
//               write          - write request
//               next_read      - pop request (discards head)
//               flush          - synchronous clear, highest priority
//               data_read      - head word (valid only when not empty)
//               full/empty     - count == DEPTH / count == 0
//               almost_full    - count >= AF_LEVEL
//               almost_empty   - count <= AE_LEVEL
//               count          - current occupancy
//               overflow       - sticky: a write was refused
//               underflow      - sticky: a pop was refused
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = FIFO_DEFAULT_AE_LEVEL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           data_write,
  input  logic                            write,
  output logic                            full,
  output logic                            almost_full,
  output logic [DATA_WIDTH-1:0]           data_read,
  input  logic                            next_read,
  output logic                            empty,
  output logic                            almost_empty,
  output logic [clog2(DEPTH + 1)-1:0]     count,
  input  logic                            flush,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  overflow_q;
  logic                  overflow_d;
  logic                  underflow_q;
  logic                  underflow_d;
  logic                  wr_acc;
  logic                  pop_acc;
  logic                  wr_en;
  logic                  pop_en;

  // A full FIFO still takes a write when the head is popped in the same
  // cycle: the new word lands in the slot being freed. An empty FIFO never
  // bypasses, so a same-cycle pop is refused.
  assign wr_acc  = write & (~full | next_read);
  assign pop_acc = next_read & ~empty;
  assign wr_en   = wr_acc & ~flush;
  assign pop_en  = pop_acc & ~flush;

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (pop_en),
    .ptr_o (rd_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= data_write;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc && !pop_acc) begin
        count_d = count_q + CW'(1);
      end else if (pop_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
      if (write && !wr_acc)      overflow_d  = 1'b1;
      if (next_read && !pop_acc) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_read    = mem_q[rd_ptr];

endmodule : fifo_flex
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flex
// Description : Self-checking bench for fifo_flex (DEPTH=6, AF=5, AE=1).
//               Table of single-cycle vectors with hand-computed results,
//               plus hand-written streaming, flush and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_write = '0;
  logic       write = 1'b0;
  logic       next_read = 1'b0;
  logic       flush = 1'b0;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [7:0] data_read;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_write   (data_write),
    .write        (write),
    .full         (full),
    .almost_full  (almost_full),
    .data_read    (data_read),
    .next_read    (next_read),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .flush        (flush),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // w r f din | pc pd (check head before edge) | cnt e full af ae ovf unf
  typedef struct {
    int w, r, f, d, pc, pd, cnt, e, fu, af, ae, o, u;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input int e, input int fu,
                           input int af, input int ae, input int o, input int u);
    chk({tag, ".count"},        int'(count),        cnt);
    chk({tag, ".empty"},        int'(empty),        e);
    chk({tag, ".full"},         int'(full),         fu);
    chk({tag, ".almost_full"},  int'(almost_full),  af);
    chk({tag, ".almost_empty"}, int'(almost_empty), ae);
    chk({tag, ".overflow"},     int'(overflow),     o);
    chk({tag, ".underflow"},    int'(underflow),    u);
  endtask

  // Drive inputs (called at edge+1), optionally check head, clock, check.
  task automatic apply(input string tag, input vec_t v);
    write      = 1'(v.w);
    next_read  = 1'(v.r);
    flush      = 1'(v.f);
    data_write = 8'(v.d);
    #1;
    if (v.pc != 0) chk({tag, ".head"}, int'(data_read), v.pd);
    @(posedge clk);
    #1;
    chk_state(tag, v.cnt, v.e, v.fu, v.af, v.ae, v.o, v.u);
    write = 1'b0; next_read = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ---- fill / overflow / drain (DEPTH=6, AF=5, AE=1)
    vecs.push_back('{1,0,0,8'h01, 0,0, 1,0,0,0,1,0,0});
    vecs.push_back('{1,0,0,8'h02, 0,0, 2,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h03, 0,0, 3,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h04, 0,0, 4,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h05, 0,0, 5,0,0,1,0,0,0});
    vecs.push_back('{1,0,0,8'h06, 0,0, 6,0,1,1,0,0,0});
    vecs.push_back('{1,0,0,8'h07, 0,0, 6,0,1,1,0,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h01, 5,0,0,1,0,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h02, 4,0,0,0,0,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h03, 3,0,0,0,0,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h04, 2,0,0,0,0,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h05, 1,0,0,0,1,1,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h06, 0,1,0,0,1,1,0});
    vecs.push_back('{0,0,1,8'h00, 0,0, 0,1,0,0,1,0,0});
    // ---- empty + write + pop: pop refused, no bypass
    vecs.push_back('{1,1,0,8'h55, 0,0, 1,0,0,0,1,0,1});
    vecs.push_back('{0,1,0,8'h00, 1,8'h55, 0,1,0,0,1,0,1});
    vecs.push_back('{0,0,1,8'h00, 0,0, 0,1,0,0,1,0,0});
    // ---- full + write + pop: new word takes freed slot, emerges last
    vecs.push_back('{1,0,0,8'h21, 0,0, 1,0,0,0,1,0,0});
    vecs.push_back('{1,0,0,8'h22, 0,0, 2,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h23, 0,0, 3,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h24, 0,0, 4,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,8'h25, 0,0, 5,0,0,1,0,0,0});
    vecs.push_back('{1,0,0,8'h26, 0,0, 6,0,1,1,0,0,0});
    vecs.push_back('{1,1,0,8'hAA, 1,8'h21, 6,0,1,1,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h22, 5,0,0,1,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h23, 4,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h24, 3,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h25, 2,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'h26, 1,0,0,0,1,0,0});
    vecs.push_back('{0,1,0,8'h00, 1,8'hAA, 0,1,0,0,1,0,0});

    // ---- reset state
    idle(2);
    rst = 1'b0;
    idle(2);
    chk_state("reset", 0, 1, 0, 0, 1, 0, 0);

    // ---- table
    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // ---- streaming wrap: 3 resident words, 20 cycles write+pop
    for (int i = 0; i < 3; i++) apply("pre", '{1,0,0,8'h10 + i, 0,0, i+1,0,0,0,(i==0)?1:0,0,0});
    for (int i = 0; i < 20; i++) begin
      apply($sformatf("stream%0d", i), '{1,1,0,8'h13 + i, 1,8'h10 + i, 3,0,0,0,0,0,0});
    end
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("drain%0d", i),
            '{0,1,0,0, 1,8'h24 + i, 2-i,(i==2)?1:0,0,0,(i>=1)?1:0,0,0});
    end

    // ---- flush at count=4 with write and pop also high
    apply("unf", '{0,1,0,0, 0,0, 0,1,0,0,1,0,1});
    for (int i = 0; i < 4; i++) apply("f4", '{1,0,0,8'h40 + i, 0,0, i+1,0,0,0,(i==0)?1:0,0,1});
    apply("flush", '{1,1,1,8'h99, 0,0, 0,1,0,0,1,0,0});
    idle(1);
    chk_state("flush_hold", 0, 1, 0, 0, 1, 0, 0);

    // ---- asynchronous reset mid-stream (overflow set beforehand)
    for (int i = 0; i < 7; i++) begin
      apply("prerst", '{1,0,0,8'h60 + i, 0,0, (i<6)?i+1:6,0,(i>=5)?1:0,(i>=4)?1:0,(i==0)?1:0,(i==6)?1:0,0});
    end
    write = 1'b1; data_write = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1, 0, 0, 1, 0, 0);
    #2;
    write = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post_rst", 0, 1, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_fifo_flex
`default_nettype wire
